// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word, opcode and fetch-state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  localparam opcode_t HALT = 6'b111111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SKID   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  function automatic logic is_halt(input word_t w);
    return w[31:26] == HALT;
  endfunction
endpackage

// File: rtl/ifid_register.sv
// rtl/ifid_register.sv - IF/ID style pipeline entry with load/hold/bubble/flush
module ifid_register
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4
);
  logic  r_valid;
  word_t r_instr;
  word_t r_pc;
  word_t r_pc4;

  // Bubble and flush only drop the valid bit; stale payload is harmless.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
      r_pc4   <= '0;
    end else if (i_flush || i_bubble) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_pc4   = r_pc4;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM feeding IF/ID; FETCH_SKID_EN adds a one-entry skid buffer
module fetch_stage
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] PC,
  input  logic [31:0] PC4,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        dec_stall,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic        pc_stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
);
  fetch_state_t r_state;

  logic  w_accept;
  logic  w_capture;
  logic  w_drain;
  logic  w_skid_halt;
  logic  w_ifid_load;
  logic  w_ifid_bubble;
  word_t w_src_instr;
  word_t w_src_pc;
  word_t w_src_pc4;

  assign w_accept = (r_state == RUN) && ihit && !dec_stall && !flush;

`ifdef FETCH_SKID_EN
  logic  w_skid_valid;
  word_t w_skid_instr;
  word_t w_skid_pc;
  word_t w_skid_pc4;

  assign w_capture = (r_state == RUN) && ihit && dec_stall && !flush;
  assign w_drain   = (r_state == SKID) && !dec_stall && !flush;

  ifid_register u_skid (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_load   (w_capture),
    .i_bubble (w_drain),
    .i_flush  (flush),
    .i_instr  (iload),
    .i_pc     (PC),
    .i_pc4    (PC4),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc),
    .o_pc4    (w_skid_pc4)
  );

  assign w_skid_halt = w_skid_valid && is_halt(w_skid_instr);
  assign w_src_instr = w_drain ? w_skid_instr : iload;
  assign w_src_pc    = w_drain ? w_skid_pc    : PC;
  assign w_src_pc4   = w_drain ? w_skid_pc4   : PC4;
`else
  assign w_capture   = 1'b0;
  assign w_drain     = 1'b0;
  assign w_skid_halt = 1'b0;
  assign w_src_instr = iload;
  assign w_src_pc    = PC;
  assign w_src_pc4   = PC4;
`endif

  assign w_ifid_load   = w_accept || w_drain;
  assign w_ifid_bubble = !dec_stall && (((r_state == RUN) && !ihit) || (r_state == HALTED));

  ifid_register u_ifid (
    .CLK      (CLK),
    .nRST     (nRST),
    .i_load   (w_ifid_load),
    .i_bubble (w_ifid_bubble),
    .i_flush  (flush),
    .i_instr  (w_src_instr),
    .i_pc     (w_src_pc),
    .i_pc4    (w_src_pc4),
    .o_valid  (ifid_valid),
    .o_instr  (ifid_instr),
    .o_pc     (ifid_pc),
    .o_pc4    (ifid_pc4)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
    end else if (flush) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept && is_halt(iload)) r_state <= HALTED;
          else if (w_capture)             r_state <= SKID;
        end
        SKID: begin
          if (w_drain) r_state <= w_skid_halt ? HALTED : RUN;
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= RUN;
      endcase
    end
  end

  // The PC is released whenever the current word is taken somewhere, or on redirect.
  always_comb begin
    iREN  = (r_state == RUN);
    iaddr = PC;
    if (flush)                 pc_stall = 1'b0;
    else if (r_state != RUN)   pc_stall = 1'b1;
    else                       pc_stall = !(w_accept || w_capture);
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] PC, PC4, iload;
  logic        ihit, dec_stall, flush;
  logic        iREN, pc_stall, ifid_valid;
  logic [31:0] iaddr, ifid_instr, ifid_pc, ifid_pc4;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .PC(PC), .PC4(PC4), .ihit(ihit), .iload(iload),
    .dec_stall(dec_stall), .flush(flush), .iREN(iREN), .iaddr(iaddr),
    .pc_stall(pc_stall), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4)
  );

  always #5 CLK = ~CLK;

`ifdef FETCH_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif
  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what decode should see, plus whether fetch is parked.
  bit          m_valid, m_halted, m_skid_full;
  logic [31:0] m_instr, m_pc, m_pc4;
  logic [31:0] m_sk_instr, m_sk_pc, m_sk_pc4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit word_is_halt(input logic [31:0] w);
    return (w >> 26) == 32'h3F;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_halted = 0; m_skid_full = 0;
    m_instr = 0; m_pc = 0; m_pc4 = 0;
  endtask

  function automatic bit exp_stall(input bit hit, input bit ds, input bit fl);
    if (fl) return 0;
    if (m_halted || m_skid_full) return 1;
    if (hit && !ds) return 0;
    if (hit && ds && SKID_EN) return 0;
    return 1;
  endfunction

  task automatic model_clock(input logic [31:0] pc, input bit hit, input logic [31:0] w,
                             input bit ds, input bit fl);
    if (fl) begin
      m_valid = 0; m_skid_full = 0; m_halted = 0;
    end else if (m_halted) begin
      if (!ds) m_valid = 0;
    end else if (m_skid_full) begin
      if (!ds) begin
        m_valid = 1; m_instr = m_sk_instr; m_pc = m_sk_pc; m_pc4 = m_sk_pc4;
        m_skid_full = 0; m_halted = word_is_halt(m_sk_instr);
      end
    end else if (hit && !ds) begin
      m_valid = 1; m_instr = w; m_pc = pc; m_pc4 = pc + 4;
      m_halted = word_is_halt(w);
    end else if (!hit && !ds) begin
      m_valid = 0;
    end else if (hit && ds && SKID_EN) begin
      m_skid_full = 1; m_sk_instr = w; m_sk_pc = pc; m_sk_pc4 = pc + 4;
    end
  endtask

  task automatic cycle(input logic [31:0] pc, input bit hit, input logic [31:0] w,
                       input bit ds, input bit fl);
    PC = pc; PC4 = pc + 4; ihit = hit; iload = w; dec_stall = ds; flush = fl;
    @(negedge CLK);
    check("iREN", {31'd0, iREN}, {31'd0, !(m_halted || m_skid_full)});
    check("iaddr", iaddr, pc);
    check("pc_stall", {31'd0, pc_stall}, {31'd0, exp_stall(hit, ds, fl)});
    @(posedge CLK);
    model_clock(pc, hit, w, ds, fl);
    #1;
    check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("ifid_instr", ifid_instr, m_instr);
      check("ifid_pc", ifid_pc, m_pc);
      check("ifid_pc4", ifid_pc4, m_pc4);
    end
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    model_reset();
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_iREN", {31'd0, iREN}, 32'd1);
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    bit hit, ds, fl;
    nRST = 1'b0; PC = 0; PC4 = 4; ihit = 0; iload = 0; dec_stall = 0; flush = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset_valid", {31'd0, ifid_valid}, 32'd0);
    check("reset_instr", ifid_instr, 32'd0);
    check("reset_pc", ifid_pc, 32'd0);
    check("reset_pc4", ifid_pc4, 32'd0);
    check("reset_iREN", {31'd0, iREN}, 32'd1);
    check("reset_stall", {31'd0, pc_stall}, 32'd1);
    nRST = 1'b1;

    cycle(32'h0, 1, 32'h2001_0005, 0, 0);
    check("first_instr", ifid_instr, 32'h2001_0005);
    check("first_pc4", ifid_pc4, 32'h4);
    cycle(32'h4, 1, 32'h2002_0001, 0, 0);
    repeat (3) cycle(32'h8, 0, 32'h0, 0, 0);
    cycle(32'h8, 1, 32'h2003_0002, 0, 0);
    check("miss_then_hit_pc", ifid_pc, 32'h8);
    cycle(32'hC, 1, 32'h2004_0003, 1, 0);
    cycle(SKID_EN ? 32'h10 : 32'hC, SKID_EN ? 0 : 1, 32'h2004_0003, 1, 0);
    cycle(SKID_EN ? 32'h10 : 32'hC, SKID_EN ? 0 : 1, 32'h2004_0003, 0, 0);
    check("stalled_pc_loads", ifid_pc, 32'hC);
    cycle(32'h10, 1, 32'h2005_0004, 0, 1);
    cycle(32'h10, 1, 32'h2005_0004, 1, 1);
    cycle(32'h10, 1, HALT_WORD, 0, 0);
    repeat (2) cycle(32'h14, 1, 32'h2006_0005, 0, 0);
    cycle(32'h14, 0, 32'h0, 0, 1);
    cycle(32'h40, 1, HALT_WORD, 0, 0);
    pulse_reset();
    cycle(32'h0, 1, 32'h2007_0006, 1, 0);
    pulse_reset();

    for (int i = 0; i < 600; i++) begin
      hit = ($urandom % 4) != 0;
      ds  = ($urandom % 4) == 0;
      fl  = ($urandom % (m_halted ? 4 : 16)) == 0;
      w   = $urandom;
      if (($urandom % 16) == 0) w = HALT_WORD;
      else if (word_is_halt(w)) w[26] = 1'b0;
      if (($urandom % 150) == 0) pulse_reset();
      cycle({$urandom_range(0, 1023), 2'b00}, hit, w, ds, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
